// File: rtl/acumulador_alu.sv
// Accumulator / writeback stage of the MicroUAZ datapath.
// Captures the ALU result or external data into the accumulator and keeps
// the Z/N/C flags. Increment and multi-cycle serial shifts are also done here.
module acumulador_alu #(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_WB   = 3'b010,
    OP_INC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  localparam logic [SHW-1:0]   CNT_ONE = SHW'(1);
  localparam logic [WIDTH-1:0] ACC_ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [SHW-1:0]   cnt, cnt_next;
  logic             dir_right, dir_right_next;
  logic [WIDTH-1:0] acc_next;
  logic             z_next, n_next, c_next, done_next;
  logic             acc_write;

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state == SHIFT);

  // Next-state, datapath and flag computation
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    dir_right_next = dir_right;
    acc_next       = acc;
    c_next         = flag_c;
    done_next      = 1'b0;
    acc_write      = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          done_next = 1'b1;
          case (op_t'(op))
            OP_LOAD: begin
              acc_next  = data_in;
              acc_write = 1'b1;
            end
            OP_WB: begin
              acc_next  = alu_result;
              c_next    = alu_carry;
              acc_write = 1'b1;
            end
            OP_INC: begin
              acc_next  = acc + ACC_ONE;
              c_next    = &acc;
              acc_write = 1'b1;
            end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                // Zero-length shift completes at once; only Z/N are refreshed.
                acc_write = 1'b1;
              end else begin
                state_next     = SHIFT;
                cnt_next       = shamt;
                dir_right_next = (op_t'(op) == OP_SHR);
                done_next      = 1'b0;
              end
            end
            OP_CLR: begin
              acc_next  = '0;
              c_next    = 1'b0;
              acc_write = 1'b1;
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        acc_write = 1'b1;
        if (dir_right) begin
          acc_next = {1'b0, acc[WIDTH-1:1]};
          c_next   = acc[0];
        end else begin
          acc_next = {acc[WIDTH-2:0], 1'b0};
          c_next   = acc[WIDTH-1];
        end
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    z_next = flag_z;
    n_next = flag_n;
    if (acc_write) begin
      z_next = (acc_next == '0);
      n_next = acc_next[WIDTH-1];
    end
  end

  // State, accumulator and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_right <= 1'b0;
      acc       <= '0;
      flag_z    <= 1'b1;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      dir_right <= dir_right_next;
      acc       <= acc_next;
      flag_z    <= z_next;
      flag_n    <= n_next;
      flag_c    <= c_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_acumulador_alu.sv
// Bench for acumulador_alu: table of single-cycle ops plus hand-written
// shift and reset sequences; every done pulse is matched against a queue.
module tb_acumulador_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic [W-1:0] data_in;
  logic [2:0]   shamt;
  logic [W-1:0] acc;
  logic         flag_z, flag_n, flag_c, busy, done;

  int total = 0;
  int bad   = 0;

  // {acc, z, n, c} expected at each done pulse
  logic [W+2:0] sb_q[$];

  acumulador_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alu_result(alu_result), .alu_carry(alu_carry),
    .data_in(data_in), .shamt(shamt), .acc(acc), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse consumes one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+2:0] e;
        e = sb_q.pop_front();
        check("done_result", {21'd0, acc, flag_z, flag_n, flag_c}, {21'd0, e});
      end
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] alu;
    logic         cin;
    logic [2:0]   sh;
    logic [W-1:0] eacc;
    logic         ez, en, ec;
  } vec_t;

  vec_t vecs[14];

  // Present one operation and let it be accepted at the next edge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] d, input logic [W-1:0] a,
                       input logic ci, input logic [2:0] s);
    op = o; data_in = d; alu_result = a; alu_carry = ci; shamt = s;
    in_valid = 1'b1;
    check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; data_in = '0;
    alu_result = '0; alu_carry = 1'b0; shamt = '0;

    vecs[0]  = '{3'b001, 8'h5A, 8'h00, 1'b0, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 8'h00, 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 8'h01, 8'h00, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 8'h00, 8'hFE, 1'b0, 3'd0, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b011, 8'h00, 8'h00, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b011, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'b010, 8'h00, 8'h33, 1'b1, 3'd0, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'b111, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{3'b110, 8'hFF, 8'hFF, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 8'h80, 8'h00, 1'b1, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'b100, 8'h00, 8'h00, 1'b1, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b010, 8'h00, 8'h7F, 1'b1, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'b001, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset held for two cycles
    @(posedge clk); #1;
    check("ready_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_in_reset2", {31'd0, in_ready}, 32'd0);
    check("reset_state", {20'd0, acc, flag_z, flag_n, flag_c, done},
          {20'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {31'd0, in_ready}, 32'd1);
    step();
    check("no_done_after_reset", {31'd0, done}, 32'd0);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 14; i++) begin
      sb_q.push_back({vecs[i].eacc, vecs[i].ez, vecs[i].en, vecs[i].ec});
      issue(vecs[i].op, vecs[i].din, vecs[i].alu, vecs[i].cin, vecs[i].sh);
      check("done_each_cycle", {31'd0, done}, 32'd1);
    end
    step();
    check("done_drops", {31'd0, done}, 32'd0);
    check("queue_drained", sb_q.size(), 32'd0);

    // SHL by 3 on 0x81, with in_valid held high while busy
    sb_q.push_back({8'h81, 1'b0, 1'b1, 1'b1});
    issue(3'b001, 8'h81, 8'h00, 1'b0, 3'd0);
    sb_q.push_back({8'h08, 1'b0, 1'b0, 1'b0});
    issue(3'b100, 8'h00, 8'h00, 1'b0, 3'd3);
    check("shl_accept_acc", {24'd0, acc}, {24'd0, 8'h81});
    check("shl_busy_ready", {30'd0, busy, in_ready}, {30'd0, 2'b10});
    op = 3'b001; data_in = 8'hFF; in_valid = 1'b1;
    step();
    check("shl_step1", {22'd0, acc, flag_c, busy}, {22'd0, 8'h02, 1'b1, 1'b1});
    check("shl_step1_ready", {31'd0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0;
    check("shl_step2", {22'd0, acc, flag_c, busy}, {22'd0, 8'h04, 1'b0, 1'b1});
    step();
    check("shl_final", {21'd0, acc, flag_c, busy, in_ready}, {21'd0, 8'h08, 1'b0, 1'b0, 1'b1});
    check("shl_done", {31'd0, done}, 32'd1);

    // SHR by 0 is single-cycle
    sb_q.push_back({8'h08, 1'b0, 1'b0, 1'b0});
    issue(3'b101, 8'h00, 8'h00, 1'b0, 3'd0);
    check("shr0_no_busy", {31'd0, busy}, 32'd0);
    step();
    check("queue_drained2", sb_q.size(), 32'd0);

    // SHR by 7 on 0xF0, aborted by reset after two steps
    sb_q.push_back({8'hF0, 1'b0, 1'b1, 1'b0});
    issue(3'b001, 8'hF0, 8'h00, 1'b0, 3'd0);
    issue(3'b101, 8'h00, 8'h00, 1'b0, 3'd7);
    step();
    check("shr_step1", {24'd0, acc}, {24'd0, 8'h78});
    step();
    check("shr_step2", {24'd0, acc}, {24'd0, 8'h3C});
    rst_n = 1'b0;
    #1;
    check("ready_low_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("abort_state", {20'd0, acc, flag_z, flag_n, flag_c, busy},
          {20'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    check("abort_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_abort", {22'd0, acc, done, in_ready}, {22'd0, 8'h00, 1'b0, 1'b1});
    step();
    check("queue_drained3", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
